// File: rtl/bypass_ctrl.sv
// Operand bypass selection and hazard stall control for an in-order pipeline.
// It tracks the last DEPTH in-flight writers and one shared multicycle unit.
module bypass_ctrl #(
  parameter int REG_AW   = 5,
  parameter int DEPTH    = 3,
  parameter int MD_LAT   = 32,
  parameter int ZERO_REG = 1,
  parameter int SEL_W    = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              advance,
  input  logic              flush,
  input  logic              dec_valid,
  input  logic [REG_AW-1:0] dec_rd,
  input  logic              dec_we,
  input  logic              dec_load,
  input  logic              dec_md,
  input  logic [REG_AW-1:0] src_a,
  input  logic [REG_AW-1:0] src_b,
  input  logic              src_a_en,
  input  logic              src_b_en,
  output logic [SEL_W-1:0]  byp_a_sel,
  output logic [SEL_W-1:0]  byp_b_sel,
  output logic              stall,
  output logic              md_busy,
  output logic              md_done,
  output logic [15:0]       stall_cycles
);

  localparam int              CNT_W   = $clog2(MD_LAT);
  localparam logic [CNT_W-1:0] MD_INIT = CNT_W'(MD_LAT - 1);
  localparam bit              ZR      = (ZERO_REG != 0);

  logic [DEPTH:1]    ent_v;
  logic [DEPTH:1]    ent_load;
  logic [REG_AW-1:0] ent_rd [1:DEPTH];

  logic [CNT_W-1:0]  md_cnt;
  logic [REG_AW-1:0] md_rd;

  logic live_a, live_b;
  logic load_use, md_raw, md_struct;
  logic accept, ins_v;

  assign live_a = src_a_en && !(ZR && (src_a == '0));
  assign live_b = src_b_en && !(ZR && (src_b == '0));

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    byp_a_sel = '0;
    byp_b_sel = '0;
    // Walk oldest to youngest so the youngest (smallest k) match is the last write.
    for (int k = DEPTH; k >= 1; k--) begin
      if (live_a && ent_v[k] && (ent_rd[k] == src_a)) byp_a_sel = SEL_W'(k);
      if (live_b && ent_v[k] && (ent_rd[k] == src_b)) byp_b_sel = SEL_W'(k);
    end
  end

  // Entry 1 is always the nearest match when it matches, so load-use only inspects it.
  assign load_use  = dec_valid && ent_v[1] && ent_load[1] &&
                     ((live_a && (ent_rd[1] == src_a)) || (live_b && (ent_rd[1] == src_b)));
  assign md_raw    = dec_valid && md_busy &&
                     ((live_a && (src_a == md_rd)) || (live_b && (src_b == md_rd)));
  assign md_struct = dec_valid && dec_md && md_busy;
  assign stall     = load_use || md_raw || md_struct;

  assign accept  = advance && !stall && dec_valid;
  assign ins_v   = dec_valid && dec_we && !dec_md && !(ZR && (dec_rd == '0));
  assign md_done = md_busy && (md_cnt == '0);

  // NOTE: the scoreboard is a handful of flops that feed hazard logic, so it is fully reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ent_v    <= '0;
      ent_load <= '0;
      for (int k = 1; k <= DEPTH; k++) ent_rd[k] <= '0;
    end else begin
      if (advance) begin
        for (int k = 2; k <= DEPTH; k++) begin
          ent_v[k]    <= ent_v[k-1];
          ent_rd[k]   <= ent_rd[k-1];
          ent_load[k] <= ent_load[k-1];
        end
        ent_v[1]    <= ins_v && !stall;
        ent_rd[1]   <= dec_rd;
        ent_load[1] <= dec_load;
      end
      // NOTE: with non-blocking assignments the last one scheduled wins, so flush overrides the insert.
      if (flush) ent_v[1] <= 1'b0;
    end
  end

  // The multicycle unit runs on its own count; pipeline hold and flush do not touch it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      md_busy <= 1'b0;
      md_cnt  <= '0;
      md_rd   <= '0;
    end else if (accept && dec_md) begin
      md_busy <= 1'b1;
      md_cnt  <= MD_INIT;
      md_rd   <= dec_rd;
    end else if (md_busy) begin
      if (md_cnt == '0) md_busy <= 1'b0;
      else              md_cnt  <= md_cnt - 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (stall && advance && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end

endmodule
